pc_next_unit: RTL and testbench
===============================

// Module: pc_next_unit
// PURPOSE
//  Program-counter stage of the single-cycle MIPS datapath, directly downstream of the
//  branch AND gate: consumes pc_src (Branch & Zero) and jump decode, selects and registers
//  the next PC, and drives the instruction-memory address. A small control FSM adds a boot
//  cycle, stall hold, and halt/resume; a retired-instruction counter supports debug.
// PARAMETERS
//  RESET_VECTOR  32'h0000_0000  PC value loaded on reset; must be word-aligned
//  CNT_W         32             width of retired_count
// PORTS
//  clk            in   1      system clock, rising edge
//  rst_n          in   1      asynchronous active-low reset
//  pc_src         in   1      branch taken (Branch & Zero from AND gate)
//  branch_offset  in   32     sign-extended 16-bit branch immediate (word offset)
//  jump           in   1      J-type jump decode
//  jump_index     in   26     instr[25:0]
//  halt           in   1      current instruction is HALT
//  stall          in   1      freeze PC this cycle
//  resume         in   1      leave HALT state
//  pc_out         out  32     current PC (instruction-memory address)
//  pc_plus4       out  32     pc_out + 4, combinational (for JAL/branch adders)
//  fetch_valid    out  1      instruction at pc_out executes this cycle
//  halted         out  1      FSM in HALT
//  retired_count  out  CNT_W  instructions retired, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Clocking: one clock; reset is asynchronous and active-low.
//  Reset (rst_n=0, immediate): pc_out=RESET_VECTOR, state=BOOT, fetch_valid=0, halted=0,
//   retired_count=0. Reset mid-operation discards any pending branch/jump/halt.
//  States: BOOT, RUN, HALT (2-bit encoding; unused encoding -> BOOT next edge).
//  BOOT: fetch_valid=0; all inputs ignored; next edge -> RUN, pc_out unchanged.
//  RUN:  fetch_valid = ~stall. On each edge:
//   - stall=1: pc_out, state, retired_count hold; all other inputs ignored.
//   - else retired_count += 1 (wraps), and next_pc by priority halt > jump > pc_src > +4:
//     halt=1   -> state=HALT, pc_out holds (points at HALT instr)
//     jump=1   -> pc_out = {pc_plus4[31:28], jump_index, 2'b00}
//     pc_src=1 -> pc_out = pc_plus4 + (branch_offset << 2), 32-bit modulo
//     else     -> pc_out = pc_plus4
//  HALT: fetch_valid=0, halted=1; stall ignored; retired_count holds.
//   resume=1 -> next edge state=RUN, pc_out = pc_out + 4 (instruction after HALT).
//   resume=0 -> hold. resume outside HALT is ignored.
//  Arithmetic: all PC adds modulo 2^32; 0xFFFF_FFFC + 4 = 0x0000_0000. Bits [1:0] of
//   pc_out stay 00 for an aligned RESET_VECTOR; no misalignment checking.
//  Outputs pc_out, halted, fetch_valid, retired_count derive only from registered state
//   (fetch_valid also from stall); pc_plus4 is combinational from pc_out.
// TESTING
//  1. Reset, release; no branch/jump -> edge1 BOOT (fetch_valid=0, pc=0), then pc 0,4,8,C;
//     retired_count 0,1,2,3.
//  2. pc=0x40, pc_src=1, branch_offset=32'hFFFF_FFFE -> next pc=0x3C; offset=3 -> 0x50.
//  3. pc=0x1000_0010, jump=1, pc_src=1, jump_index=26'h0000100 -> next pc=0x1000_0400.
//  4. stall=1 for 3 cycles at pc=0x20 -> pc, retired_count frozen, fetch_valid=0; then +4.
//  5. halt=1 with jump=1 at pc=0x30 -> HALT, pc=0x30, halted=1; resume 5 cycles later
//     -> RUN, pc=0x34; count +1 only for the HALT instr.
//  6. RESET_VECTOR=32'hFFFF_FFF8: pc FFFF_FFF8 -> FFFF_FFFC -> 0000_0000; assert rst_n=0
//     mid-cycle during a branch -> pc_out=RESET_VECTOR immediately, state=BOOT.

Source files
------------

// File: rtl/pc_next_unit_if.sv
// rtl/pc_next_unit_if.sv - next-PC stage bus: branch/jump/control inputs and PC/status outputs
//
// Purpose: bundles every signal of pc_next_unit except clk/rst_n.
// Ports (as seen from the slave, i.e. the PC unit):
//   in : pc_src, branch_offset[31:0], jump, jump_index[25:0], halt, stall, resume
//   out: pc_out[31:0], pc_plus4[31:0], fetch_valid, halted, retired_count[CNT_W-1:0]
interface pc_next_unit_if #(
  parameter int CNT_W = 32
);
  logic             pc_src;
  logic [31:0]      branch_offset;
  logic             jump;
  logic [25:0]      jump_index;
  logic             halt;
  logic             stall;
  logic             resume;
  logic [31:0]      pc_out;
  logic [31:0]      pc_plus4;
  logic             fetch_valid;
  logic             halted;
  logic [CNT_W-1:0] retired_count;

  modport master (
    output pc_src, branch_offset, jump, jump_index, halt, stall, resume,
    input  pc_out, pc_plus4, fetch_valid, halted, retired_count
  );

  modport slave (
    input  pc_src, branch_offset, jump, jump_index, halt, stall, resume,
    output pc_out, pc_plus4, fetch_valid, halted, retired_count
  );
endinterface

// File: rtl/pc_next_unit.sv
// rtl/pc_next_unit.sv - program-counter stage with boot/run/halt control and retire counter
//
// Purpose: selects and registers the next PC (halt > jump > branch > +4), adds a boot
// cycle after reset, freezes on stall, parks on HALT until resume, counts retired instrs.
// Ports:
//   clk    in  system clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport of pc_next_unit_if (control inputs, PC and status outputs)
module pc_next_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          CNT_W        = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  pc_next_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    S_BOOT = 2'b00,
    S_RUN  = 2'b01,
    S_HALT = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_VECTOR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_BOOT: state_d = S_RUN;
      S_RUN: begin
        if (!bus.stall) begin
          // Every unstalled RUN cycle retires the instruction at pc_q, HALT included.
          cnt_d = cnt_q + CNT_W'(1);
          if (bus.halt) begin
            state_d = S_HALT;           // pc stays on the HALT instruction
          end else if (bus.jump) begin
            pc_d = {pc_plus4[31:28], bus.jump_index, 2'b00};
          end else if (bus.pc_src) begin
            pc_d = pc_plus4 + (bus.branch_offset << 2);
          end else begin
            pc_d = pc_plus4;
          end
        end
      end
      S_HALT: begin
        if (bus.resume) begin
          state_d = S_RUN;
          pc_d    = pc_plus4;           // continue after the HALT instruction
        end
      end
      default: state_d = S_BOOT;        // unused encoding recovers via boot
    endcase
  end

  assign bus.pc_out        = pc_q;
  assign bus.pc_plus4      = pc_plus4;
  assign bus.fetch_valid   = (state_q == S_RUN) && !bus.stall;
  assign bus.halted        = (state_q == S_HALT);
  assign bus.retired_count = cnt_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// tb/tb_pc_next_unit.sv - directed self-checking bench for pc_next_unit
module tb_pc_next_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n  = 1'b0;
  logic rst1_n = 1'b0;

  pc_next_unit_if #(.CNT_W(32)) bus0 ();
  pc_next_unit_if #(.CNT_W(32)) bus1 ();

  pc_next_unit #(.RESET_VECTOR(32'h0000_0000), .CNT_W(32)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.slave)
  );

  pc_next_unit #(.RESET_VECTOR(32'hFFFF_FFF8), .CNT_W(32)) u_dut1 (
    .clk   (clk),
    .rst_n (rst1_n),
    .bus   (bus1.slave)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_cnt;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus0.pc_src = 0; bus0.branch_offset = 0; bus0.jump = 0; bus0.jump_index = 0;
    bus0.halt = 0; bus0.stall = 0; bus0.resume = 0;
    bus1.pc_src = 0; bus1.branch_offset = 0; bus1.jump = 0; bus1.jump_index = 0;
    bus1.halt = 0; bus1.stall = 0; bus1.resume = 0;
  endtask

  // Stimulus-only: one unstalled RUN jump on dut0
  task automatic do_jump(input logic [25:0] idx);
    bus0.jump = 1; bus0.jump_index = idx;
    tick();
    bus0.jump = 0;
    exp_cnt = exp_cnt + 1;
  endtask

  task automatic do_branch(input logic [31:0] off);
    bus0.pc_src = 1; bus0.branch_offset = off;
    tick();
    bus0.pc_src = 0;
    exp_cnt = exp_cnt + 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    tick();
    n_tests++; if (bus0.pc_out !== 32'h0) begin n_fail++; $display("FAIL rst_pc got=%h exp=%h", bus0.pc_out, 32'h0); end
    n_tests++; if (bus0.fetch_valid !== 1'b0) begin n_fail++; $display("FAIL rst_fv got=%b exp=0", bus0.fetch_valid); end
    n_tests++; if (bus0.halted !== 1'b0) begin n_fail++; $display("FAIL rst_halted got=%b exp=0", bus0.halted); end
    n_tests++; if (bus0.retired_count !== 32'h0) begin n_fail++; $display("FAIL rst_cnt got=%0d exp=0", bus0.retired_count); end
    rst_n = 1;
    #1;
    n_tests++; if (bus0.fetch_valid !== 1'b0) begin n_fail++; $display("FAIL boot_fv got=%b exp=0", bus0.fetch_valid); end
    tick();
    n_tests++; if (bus0.pc_out !== 32'h0) begin n_fail++; $display("FAIL boot_pc got=%h exp=0", bus0.pc_out); end
    n_tests++; if (bus0.fetch_valid !== 1'b1) begin n_fail++; $display("FAIL run_fv got=%b exp=1", bus0.fetch_valid); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_tests++; if (bus0.pc_out !== 32'(i * 4)) begin n_fail++; $display("FAIL seq_pc%0d got=%h exp=%h", i, bus0.pc_out, 32'(i * 4)); end
      n_tests++; if (bus0.retired_count !== 32'(i)) begin n_fail++; $display("FAIL seq_cnt%0d got=%0d exp=%0d", i, bus0.retired_count, i); end
    end
    n_tests++; if (bus0.pc_plus4 !== 32'h10) begin n_fail++; $display("FAIL pc_plus4 got=%h exp=%h", bus0.pc_plus4, 32'h10); end
    exp_cnt = 3;
  endtask

  task automatic test_branch();
    do_jump(26'h10);
    n_tests++; if (bus0.pc_out !== 32'h40) begin n_fail++; $display("FAIL jmp40 got=%h exp=%h", bus0.pc_out, 32'h40); end
    do_branch(32'hFFFF_FFFE);
    n_tests++; if (bus0.pc_out !== 32'h3C) begin n_fail++; $display("FAIL br_neg got=%h exp=%h", bus0.pc_out, 32'h3C); end
    do_jump(26'h10);
    do_branch(32'h0000_0003);
    n_tests++; if (bus0.pc_out !== 32'h50) begin n_fail++; $display("FAIL br_pos got=%h exp=%h", bus0.pc_out, 32'h50); end
    n_tests++; if (bus0.retired_count !== exp_cnt) begin n_fail++; $display("FAIL br_cnt got=%0d exp=%0d", bus0.retired_count, exp_cnt); end
  endtask

  task automatic test_jump_priority();
    do_branch(32'h03FF_FFEF);   // 0x54 + 0x0FFF_FFBC
    n_tests++; if (bus0.pc_out !== 32'h1000_0010) begin n_fail++; $display("FAIL far_br got=%h exp=%h", bus0.pc_out, 32'h1000_0010); end
    bus0.jump = 1; bus0.pc_src = 1; bus0.jump_index = 26'h0000100; bus0.branch_offset = 32'h3;
    tick();
    bus0.jump = 0; bus0.pc_src = 0;
    exp_cnt = exp_cnt + 1;
    n_tests++; if (bus0.pc_out !== 32'h1000_0400) begin n_fail++; $display("FAIL jmp_prio got=%h exp=%h", bus0.pc_out, 32'h1000_0400); end
    n_tests++; if (bus0.retired_count !== exp_cnt) begin n_fail++; $display("FAIL jmp_cnt got=%0d exp=%0d", bus0.retired_count, exp_cnt); end
  endtask

  task automatic test_stall();
    do_branch(32'h3BFF_FF07);   // 0x1000_0404 + 0xEFFF_FC1C wraps to 0x20
    n_tests++; if (bus0.pc_out !== 32'h20) begin n_fail++; $display("FAIL to20 got=%h exp=%h", bus0.pc_out, 32'h20); end
    bus0.stall = 1; bus0.jump = 1; bus0.halt = 1; bus0.jump_index = 26'h3FF;
    #1;
    n_tests++; if (bus0.fetch_valid !== 1'b0) begin n_fail++; $display("FAIL stall_fv got=%b exp=0", bus0.fetch_valid); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++; if (bus0.pc_out !== 32'h20) begin n_fail++; $display("FAIL stall_pc%0d got=%h exp=%h", i, bus0.pc_out, 32'h20); end
      n_tests++; if (bus0.retired_count !== exp_cnt) begin n_fail++; $display("FAIL stall_cnt%0d got=%0d exp=%0d", i, bus0.retired_count, exp_cnt); end
      n_tests++; if (bus0.halted !== 1'b0) begin n_fail++; $display("FAIL stall_halted%0d got=%b exp=0", i, bus0.halted); end
    end
    bus0.stall = 0; bus0.jump = 0; bus0.halt = 0;
    #1;
    n_tests++; if (bus0.fetch_valid !== 1'b1) begin n_fail++; $display("FAIL unstall_fv got=%b exp=1", bus0.fetch_valid); end
    tick();
    exp_cnt = exp_cnt + 1;
    n_tests++; if (bus0.pc_out !== 32'h24) begin n_fail++; $display("FAIL unstall_pc got=%h exp=%h", bus0.pc_out, 32'h24); end
    n_tests++; if (bus0.retired_count !== exp_cnt) begin n_fail++; $display("FAIL unstall_cnt got=%0d exp=%0d", bus0.retired_count, exp_cnt); end
  endtask

  task automatic test_halt_resume();
    do_jump(26'h0C);
    n_tests++; if (bus0.pc_out !== 32'h30) begin n_fail++; $display("FAIL to30 got=%h exp=%h", bus0.pc_out, 32'h30); end
    bus0.halt = 1; bus0.jump = 1; bus0.jump_index = 26'h55;
    tick();
    exp_cnt = exp_cnt + 1;
    n_tests++; if (bus0.pc_out !== 32'h30) begin n_fail++; $display("FAIL halt_pc got=%h exp=%h", bus0.pc_out, 32'h30); end
    n_tests++; if (bus0.halted !== 1'b1) begin n_fail++; $display("FAIL halt_flag got=%b exp=1", bus0.halted); end
    n_tests++; if (bus0.fetch_valid !== 1'b0) begin n_fail++; $display("FAIL halt_fv got=%b exp=0", bus0.fetch_valid); end
    bus0.halt = 0; bus0.stall = 1;   // jump still high: must be ignored in HALT
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++; if (bus0.pc_out !== 32'h30 || bus0.halted !== 1'b1) begin n_fail++; $display("FAIL halt_hold%0d got pc=%h halted=%b exp pc=%h halted=1", i, bus0.pc_out, bus0.halted, 32'h30); end
      n_tests++; if (bus0.retired_count !== exp_cnt) begin n_fail++; $display("FAIL halt_cnt%0d got=%0d exp=%0d", i, bus0.retired_count, exp_cnt); end
    end
    bus0.resume = 1; bus0.stall = 0; bus0.jump = 0;
    tick();
    n_tests++; if (bus0.pc_out !== 32'h34) begin n_fail++; $display("FAIL resume_pc got=%h exp=%h", bus0.pc_out, 32'h34); end
    n_tests++; if (bus0.halted !== 1'b0 || bus0.fetch_valid !== 1'b1) begin n_fail++; $display("FAIL resume_state got halted=%b fv=%b exp halted=0 fv=1", bus0.halted, bus0.fetch_valid); end
    n_tests++; if (bus0.retired_count !== exp_cnt) begin n_fail++; $display("FAIL resume_cnt got=%0d exp=%0d", bus0.retired_count, exp_cnt); end
    tick();   // resume still high while running: ignored
    bus0.resume = 0;
    exp_cnt = exp_cnt + 1;
    n_tests++; if (bus0.pc_out !== 32'h38) begin n_fail++; $display("FAIL run_resume_pc got=%h exp=%h", bus0.pc_out, 32'h38); end
    n_tests++; if (bus0.retired_count !== exp_cnt) begin n_fail++; $display("FAIL run_resume_cnt got=%0d exp=%0d", bus0.retired_count, exp_cnt); end
  endtask

  task automatic test_wrap_and_async_reset();
    n_tests++; if (bus1.pc_out !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL rv_rst_pc got=%h exp=%h", bus1.pc_out, 32'hFFFF_FFF8); end
    rst1_n = 1;
    tick();
    n_tests++; if (bus1.pc_out !== 32'hFFFF_FFF8 || bus1.fetch_valid !== 1'b1) begin n_fail++; $display("FAIL rv_boot got pc=%h fv=%b exp pc=%h fv=1", bus1.pc_out, bus1.fetch_valid, 32'hFFFF_FFF8); end
    tick();
    n_tests++; if (bus1.pc_out !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL rv_pc1 got=%h exp=%h", bus1.pc_out, 32'hFFFF_FFFC); end
    n_tests++; if (bus1.pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL rv_plus4_wrap got=%h exp=0", bus1.pc_plus4); end
    tick();
    n_tests++; if (bus1.pc_out !== 32'h0) begin n_fail++; $display("FAIL rv_wrap got=%h exp=0", bus1.pc_out); end
    n_tests++; if (bus1.retired_count !== 32'd2) begin n_fail++; $display("FAIL rv_cnt got=%0d exp=2", bus1.retired_count); end
    bus1.pc_src = 1; bus1.branch_offset = 32'h5;
    #3;
    rst1_n = 0;
    #1;
    n_tests++; if (bus1.pc_out !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL arst_pc got=%h exp=%h", bus1.pc_out, 32'hFFFF_FFF8); end
    n_tests++; if (bus1.fetch_valid !== 1'b0 || bus1.retired_count !== 32'h0) begin n_fail++; $display("FAIL arst_state got fv=%b cnt=%0d exp fv=0 cnt=0", bus1.fetch_valid, bus1.retired_count); end
    tick();
    rst1_n = 1;
    tick();   // boot edge: pending branch ignored
    n_tests++; if (bus1.pc_out !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL arst_boot_pc got=%h exp=%h", bus1.pc_out, 32'hFFFF_FFF8); end
    tick();   // FFFF_FFFC + 0x14
    bus1.pc_src = 0;
    n_tests++; if (bus1.pc_out !== 32'h10) begin n_fail++; $display("FAIL rv_branch_wrap got=%h exp=%h", bus1.pc_out, 32'h10); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_branch();
    test_jump_priority();
    test_stall();
    test_halt_resume();
    test_wrap_and_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
